// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch, decode and execute micro-steps for
// load/store and immediate-ALU instructions, producing one-hot datapath strobes.
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MD_read,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zlowout,
  output logic        Gra,
  output logic        Grb,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Csignout,
  output logic        ADD,
  output logic        AND,
  output logic        OR,
  output logic        Run,
  output logic [4:0]  state
);

  typedef enum logic [4:0] {
    S_IDLE   = 5'd0,
    S_T0     = 5'd1,
    S_T1     = 5'd2,
    S_T2     = 5'd3,
    S_T3     = 5'd4,
    S_T4     = 5'd5,
    S_T5     = 5'd6,
    S_T6     = 5'd7,
    S_T7     = 5'd8,
    S_T8     = 5'd9,
    S_HALTED = 5'd31
  } state_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  state_t         cur, nxt;
  logic [OPW-1:0] opcode;
  logic [OPW-1:0] ir_op;
  logic           ir_exec;
  logic           mem_op;
  logic           unused_ir_bits;

  assign ir_op          = IR[31 -: OPW];
  assign unused_ir_bits = ^IR[31-OPW:0];
  assign state          = cur;

  // Only these opcodes leave decode for T4; nop and illegal codes refetch.
  assign ir_exec = (ir_op == OP_LD)   || (ir_op == OP_LDI)  || (ir_op == OP_ST) ||
                   (ir_op == OP_ADDI) || (ir_op == OP_ANDI) || (ir_op == OP_ORI);
  assign mem_op  = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cur    <= S_IDLE;
      opcode <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_T3) opcode <= ir_op;
    end
  end

  always_comb begin
    nxt      = cur;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    MD_read  = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zlowout  = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    BAout    = 1'b0;
    Csignout = 1'b0;
    ADD      = 1'b0;
    AND      = 1'b0;
    OR       = 1'b0;
    Run      = 1'b1;
    case (cur)
      S_IDLE: begin
        Run = 1'b0;
        nxt = S_T0;
      end
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        nxt = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MD_read = 1'b1; MDRin = 1'b1;
        nxt = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        nxt = S_T3;
      end
      S_T3: begin
        if (ir_op == OP_HALT) nxt = S_HALTED;
        else if (ir_exec)     nxt = S_T4;
        else                  nxt = S_T0;
      end
      S_T4: begin
        Grb = 1'b1; Yin = 1'b1;
        if (mem_op) BAout = 1'b1;
        else        Rout  = 1'b1;
        nxt = S_T5;
      end
      S_T5: begin
        Csignout = 1'b1; Zlowin = 1'b1;
        if (opcode == OP_ANDI)     AND = 1'b1;
        else if (opcode == OP_ORI) OR  = 1'b1;
        else                       ADD = 1'b1;
        nxt = S_T6;
      end
      S_T6: begin
        Zlowout = 1'b1;
        if (opcode == OP_LD || opcode == OP_ST) begin
          MARin = 1'b1;
          nxt   = S_T7;
        end else begin
          Gra = 1'b1; Rin = 1'b1;
          nxt = S_T0;
        end
      end
      S_T7: begin
        MDRin = 1'b1;
        // Store takes MDR from the bus; load takes it from memory.
        if (opcode == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1;
        end else begin
          Read = 1'b1; MD_read = 1'b1;
        end
        nxt = S_T8;
      end
      S_T8: begin
        if (opcode == OP_ST) Write = 1'b1;
        else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
        nxt = S_T0;
      end
      S_HALTED: begin
        Run = 1'b0;
        nxt = S_HALTED;
      end
      default: begin
        Run = 1'b0;
        nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instructions then random ones, each
// cycle's state and strobe set compared to a micro-step list built from opcode.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, Read, Write, IRin;
  logic Yin, Zlowin, Zlowout, Gra, Grb, Rin, Rout, BAout, Csignout;
  logic ADD, AND, OR, Run;
  logic [4:0] state;

  int checks   = 0;
  int failures = 0;
  logic [27:0] exp_q[$];

  localparam logic [22:0] ONE = 23'd1;
  localparam logic [22:0] M_PCOUT = ONE << 22, M_PCIN = ONE << 21, M_INCPC = ONE << 20;
  localparam logic [22:0] M_MARIN = ONE << 19, M_MDRIN = ONE << 18, M_MDROUT = ONE << 17;
  localparam logic [22:0] M_MDREAD = ONE << 16, M_READ = ONE << 15, M_WRITE = ONE << 14;
  localparam logic [22:0] M_IRIN = ONE << 13, M_YIN = ONE << 12, M_ZLOWIN = ONE << 11;
  localparam logic [22:0] M_ZLOWOUT = ONE << 10, M_GRA = ONE << 9, M_GRB = ONE << 8;
  localparam logic [22:0] M_RIN = ONE << 7, M_ROUT = ONE << 6, M_BAOUT = ONE << 5;
  localparam logic [22:0] M_CSIGN = ONE << 4, M_ADD = ONE << 3, M_AND = ONE << 2;
  localparam logic [22:0] M_OR = ONE << 1, M_RUN = ONE;

  logic [22:0] strobes;
  assign strobes = {PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, Read, Write,
                    IRin, Yin, Zlowin, Zlowout, Gra, Grb, Rin, Rout, BAout, Csignout,
                    ADD, AND, OR, Run};

  control_sequencer #(.OPW(5)) dut (
    .clock(clock), .clear(clear), .IR(IR),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .MD_read(MD_read), .Read(Read), .Write(Write), .IRin(IRin),
    .Yin(Yin), .Zlowin(Zlowin), .Zlowout(Zlowout), .Gra(Gra), .Grb(Grb), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .Csignout(Csignout), .ADD(ADD), .AND(AND), .OR(OR),
    .Run(Run), .state(state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got state=%0d strobes=%06h, expected state=%0d strobes=%06h",
               tag, obs[27:23], obs[22:0], exp[27:23], exp[22:0]);
    end
  endtask

  // Reference model: micro-step list of {state, strobes} for one instruction.
  task automatic build_expected(input logic [4:0] op);
    logic [22:0] alu;
    exp_q.push_back({5'd1, M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN | M_RUN});
    exp_q.push_back({5'd2, M_ZLOWOUT | M_PCIN | M_READ | M_MDREAD | M_MDRIN | M_RUN});
    exp_q.push_back({5'd3, M_MDROUT | M_IRIN | M_RUN});
    exp_q.push_back({5'd4, M_RUN});
    case (op)
      5'b00000, 5'b00001, 5'b00010: begin
        exp_q.push_back({5'd5, M_GRB | M_BAOUT | M_YIN | M_RUN});
        exp_q.push_back({5'd6, M_CSIGN | M_ADD | M_ZLOWIN | M_RUN});
        if (op == 5'b00001) begin
          exp_q.push_back({5'd7, M_ZLOWOUT | M_GRA | M_RIN | M_RUN});
        end else begin
          exp_q.push_back({5'd7, M_ZLOWOUT | M_MARIN | M_RUN});
          if (op == 5'b00000) begin
            exp_q.push_back({5'd8, M_READ | M_MDREAD | M_MDRIN | M_RUN});
            exp_q.push_back({5'd9, M_MDROUT | M_GRA | M_RIN | M_RUN});
          end else begin
            exp_q.push_back({5'd8, M_GRA | M_ROUT | M_MDRIN | M_RUN});
            exp_q.push_back({5'd9, M_WRITE | M_RUN});
          end
        end
      end
      5'b01100, 5'b01101, 5'b01110: begin
        alu = (op == 5'b01100) ? M_ADD : (op == 5'b01101) ? M_AND : M_OR;
        exp_q.push_back({5'd5, M_GRB | M_ROUT | M_YIN | M_RUN});
        exp_q.push_back({5'd6, M_CSIGN | M_ZLOWIN | alu | M_RUN});
        exp_q.push_back({5'd7, M_ZLOWOUT | M_GRA | M_RIN | M_RUN});
      end
      5'b11011: for (int i = 0; i < 20; i++) exp_q.push_back({5'd31, 23'd0});
      default: ;
    endcase
  endtask

  // Entered at a negedge; returns at the negedge inside the following T0.
  task automatic do_clear(input string tag);
    #2 clear = 1'b1;
    #1 check({tag, "_async"}, {state, strobes}, 28'd0);
    @(posedge clock);
    #1 check({tag, "_held"}, {state, strobes}, 28'd0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
  endtask

  // Driver: entered at the negedge inside T0. abort_at >= 0 clears after that step.
  task automatic run_instr(input string tag, input logic [31:0] ir_val, input int abort_at);
    int n;
    logic [27:0] exp;
    IR = ir_val;
    exp_q.delete();
    build_expected(ir_val[31:27]);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clock);
      exp = exp_q.pop_front();
      check($sformatf("%s_step%0d", tag, i), {state, strobes}, exp);
      if (i == 4) IR = $urandom;  // later IR changes must not matter
      if (i == abort_at) begin
        do_clear({tag, "_midclear"});
        return;
      end
    end
    if (ir_val[31:27] == 5'b11011) do_clear({tag, "_unhalt"});
    else @(negedge clock);
  endtask

  initial begin
    logic [4:0] op;
    clear = 1'b1;
    IR = 32'd0;
    #1 check("reset", {state, strobes}, 28'd0);
    repeat (2) @(posedge clock);
    #1 check("reset_idle", {state, strobes}, 28'd0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    run_instr("ldi_abort", 32'h08800065, 5);
    run_instr("ldi", 32'h08800065, -1);
    run_instr("ld", 32'h01080095, -1);
    run_instr("st", 32'h10800087, -1);
    run_instr("andi", 32'h69100003, -1);
    run_instr("illegal", 32'hF8000000, -1);
    run_instr("ori", 32'h71100042, -1);
    run_instr("addi", 32'h61100001, -1);
    run_instr("nop", 32'hD0000000, -1);
    run_instr("halt", 32'hD8000000, -1);

    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 9))
        0: op = 5'b00000;
        1: op = 5'b00001;
        2: op = 5'b00010;
        3: op = 5'b01100;
        4: op = 5'b01101;
        5: op = 5'b01110;
        6: op = 5'b11010;
        7: op = ($urandom_range(0, 3) == 0) ? 5'b11011 : 5'b00001;
        default: op = 5'($urandom_range(0, 31));
      endcase
      run_instr($sformatf("rnd%0d", k), {op, 27'($urandom)},
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
